// File: rtl/parallel_out_pkg.sv
// Shared definitions for the parallel output bank: channel op encoding and default parameters.
package parallel_out_pkg;

  typedef enum logic [1:0] {
    OP_WR  = 2'd0,
    OP_SET = 2'd1,
    OP_CLR = 2'd2,
    OP_TGL = 2'd3
  } op_e;

  localparam int          DEF_DATA_W    = 8;
  localparam int          DEF_ADDR_W    = 8;
  localparam int          DEF_N_CH      = 4;
  localparam int unsigned DEF_BASE_ADDR = 32'h0000_00F0;

endpackage

// File: rtl/parallel_out_channel.sv
// One output channel: value register, WR/SET/CLR/TGL op logic and a change-pulse flop.
module parallel_out_channel
  import parallel_out_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  op_e               op,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] value,
  output logic              updated
);

  logic [DATA_W-1:0] next_value;
  logic              changed;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    next_value = value;
    unique case (op)
      OP_WR:  next_value = wdata;
      OP_SET: next_value = value | wdata;
      OP_CLR: next_value = value & ~wdata;
      OP_TGL: next_value = value ^ wdata;
      default: next_value = value;
    endcase
  end

  // A write that leaves the value as it was must not pulse.
  assign changed = sel && (next_value != value);

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      value   <= '0;
      updated <= 1'b0;
    end else begin
      if (changed) value <= next_value;
      updated <= changed;
    end
  end

endmodule

// File: rtl/parallel_out_bank.sv
// Memory-mapped bank of N_CH output channels with per-channel op regions and optional readback.
// Readback is compiled in only when PARALLEL_OUT_READBACK_EN is defined.
module parallel_out_bank
  import parallel_out_pkg::*;
#(
  parameter int          DATA_W    = DEF_DATA_W,
  parameter int          ADDR_W    = DEF_ADDR_W,
  parameter int          N_CH      = DEF_N_CH,
  parameter int unsigned BASE_ADDR = DEF_BASE_ADDR
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         we,
  input  logic                         re,
  input  logic [ADDR_W-1:0]            Address,
  input  logic [DATA_W-1:0]            WriteData,
  output logic                         hit,
  output logic [DATA_W-1:0]            ReadData,
  output logic [N_CH-1:0][DATA_W-1:0]  DataOut,
  output logic [N_CH-1:0]              Updated
);

  localparam int WIN = 4 * N_CH;

  if (N_CH < 1 || N_CH > 16 || (N_CH & (N_CH - 1)) != 0) begin : g_bad_n_ch
    $error("parallel_out_bank: N_CH must be a power of two in 1..16");
  end
  if ((BASE_ADDR % WIN) != 0 ||
      (longint'(BASE_ADDR) + longint'(WIN)) > (longint'(1) << ADDR_W)) begin : g_bad_base
    $error("parallel_out_bank: BASE_ADDR misaligned or window exceeds address space");
  end

  logic [ADDR_W-1:0] offset;
  int                off_i;
  int                ch_idx;
  op_e               op;

  // Offset wraps below BASE_ADDR, so the lower-bound compare is kept explicit.
  assign offset = Address - ADDR_W'(BASE_ADDR);
  assign off_i  = int'(offset);
  assign hit    = (Address >= ADDR_W'(BASE_ADDR)) && (off_i < WIN);
  assign ch_idx = off_i % N_CH;
  assign op     = op_e'(2'(off_i / N_CH));

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    parallel_out_channel #(
      .DATA_W (DATA_W)
    ) u_channel (
      .clk     (clk),
      .reset   (reset),
      .sel     (we && hit && (ch_idx == i)),
      .op      (op),
      .wdata   (WriteData),
      .value   (DataOut[i]),
      .updated (Updated[i])
    );
  end

`ifdef PARALLEL_OUT_READBACK_EN
  logic [DATA_W-1:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_idx == i) rd_mux = DataOut[i];
    end
  end

  // DataOut is read before this edge's write lands, so re+we returns the old value.
  always_ff @(posedge clk) begin
    if (reset)            ReadData <= '0;
    else if (re && hit)   ReadData <= rd_mux;
    else                  ReadData <= '0;
  end
`else
  logic unused_re;
  assign unused_re = re;
  assign ReadData  = '0;
`endif

endmodule

// File: doc/parallel_out_bank.md
PARALLEL_OUT_BANK -- requirements
Module: parallel_out_bank

Interface
REQ-001 Parameter DATA_W, 8, width of each output channel and of the data bus.
REQ-002 Parameter ADDR_W, 8, width of the address bus.
REQ-003 Parameter N_CH, 4, number of output channels; SHALL be a power of two, 1..16.
REQ-004 Parameter BASE_ADDR, 8'hF0, first mapped address; SHALL be aligned to 4*N_CH, and BASE_ADDR+4*N_CH SHALL be <= 2**ADDR_W.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 we  input  1  write enable from the processor data port.
REQ-008 re  input  1  read enable from the processor data port.
REQ-009 Address  input  ADDR_W  processor data address.
REQ-010 WriteData  input  DATA_W  store data.
REQ-011 hit  output  1  combinational; high when Address is inside the mapped window.
REQ-012 ReadData  output  DATA_W  registered readback data.
REQ-013 DataOut  output  N_CH x DATA_W  registered channel values that drive the pins.
REQ-014 Updated  output  N_CH  one-cycle change pulse per channel.

Function
REQ-015 Window: offset = Address - BASE_ADDR, valid for 0 <= offset < 4*N_CH; ch = offset mod N_CH; op = offset / N_CH.
REQ-016 The op encoding SHALL be 0=WR (load), 1=SET (OR), 2=CLR (AND NOT), 3=TGL (XOR), each applied to channel ch with WriteData.
REQ-017 On the clock edge where we=1 and hit=1, DataOut[ch] SHALL take the op result; the new value is visible after that edge.
REQ-018 A write with hit=0 SHALL change no state.
REQ-019 Only the addressed channel SHALL change; all other channels hold their values.
REQ-020 Updated[ch] SHALL be high for exactly the one cycle after an edge at which DataOut[ch] changed value; a write that leaves the value unchanged SHALL NOT pulse.
REQ-021 Back-to-back writes to one channel on consecutive cycles SHALL each apply in order; Updated stays high for every cycle that follows a changing write.
REQ-022 On an edge with re=1 and hit=1, ReadData SHALL load DataOut[ch] (read latency 1 cycle, any op region); otherwise ReadData SHALL load 0.
REQ-023 With we=1 and re=1 to the same channel in the same cycle, ReadData SHALL return the pre-write value.
REQ-024 Op arithmetic is bitwise at DATA_W; there is no carry or wrap.

Reset
REQ-025 While reset=1 at an edge, DataOut, ReadData and Updated SHALL become all zeros.
REQ-026 Reset SHALL take priority over any simultaneous we or re.
REQ-027 The edge that leaves reset SHALL NOT pulse Updated.

Configuration
REQ-028 Macro PARALLEL_OUT_READBACK_EN SHALL compile readback in or out.
REQ-029 With PARALLEL_OUT_READBACK_EN defined, behaviour SHALL follow REQ-022 and REQ-023.
REQ-030 Without PARALLEL_OUT_READBACK_EN, ReadData SHALL be constant 0, re SHALL be ignored, and no readback flops SHALL exist.

Structure
REQ-031 Package parallel_out_pkg SHALL hold the op_e enum (OP_WR, OP_SET, OP_CLR, OP_TGL) and the default parameter constants.
REQ-032 Sub-module parallel_out_channel SHALL implement one channel: its register, op logic and Updated flop; the top SHALL instantiate it N_CH times and hold the decode and readback logic.
REQ-033 Parameter legality from REQ-003 and REQ-004 SHALL be checked at elaboration.

Verification (N_CH=4, DATA_W=8, BASE_ADDR=8'hF0)
REQ-034 Reset, then we to F2 with A5 -> DataOut[2]=A5 after the edge, Updated=4'b0100 for one cycle, other channels stay 00.
REQ-035 Ch1=30, then SET F5 with 0F -> 3F; CLR F9 with 21 -> 1E; TGL FD with FF -> E1; Updated[1] pulses each time.
REQ-036 Ch1=E1, then WR F1 with E1 -> no Updated pulse; we to EF with 55 -> hit=0 and no change anywhere.
REQ-037 Ch2=A5, then re+we to FE with FF in the same cycle -> ReadData=A5 next cycle and DataOut[2]=5A; re alone to EE -> ReadData=00.
REQ-038 Reset asserted together with we to F3 (77) in the middle of traffic -> all outputs 00 and no Updated pulse.
REQ-039 Build without PARALLEL_OUT_READBACK_EN, re to F0 -> ReadData stays 00.
